// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one synchronous-read data RAM (separate read/write address ports,
//   1-cycle read latency) between the CPU load/store path (port 0) and a
//   secondary master such as DMA or a debug loader (port 1). At most one RAM
//   operation is issued per cycle. Read data is routed back to the port that
//   issued the read.
//
//   Optional feature macro: RAM_ARB_STARVE_GUARD_EN
//     defined   : a saturating counter tracks contested cycles lost by port 1.
//                 Once it reaches STARVE_LIMIT, port 1 wins the next contested
//                 cycle.
//     undefined : port 0 has strict fixed priority.
//
// Ports
//   clk, rst             clock (RAM domain), async active-high reset
//   req*/we*/addr*/wdata* request valid, write select, word address, write data
//   gnt0/gnt1            combinational accept; the op completes at that edge
//   rvalid*/rdata*       one-cycle read return; rdata is 0 while rvalid is low
//   ramWe/ramWaddr/ramWdata/ramRaddr  RAM control; addresses are 0 when unused
//   ramRdata             RAM read data, valid one cycle after ramRaddr
//   oorErr               pulse: the previous granted request was out of range
module ram_port_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int DEPTH        = 8192,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  ramWe,
    output logic [ADDR_WIDTH-1:0] ramWaddr,
    output logic [ADDR_WIDTH-1:0] ramRaddr,
    output logic [DATA_WIDTH-1:0] ramWdata,
    input  logic [DATA_WIDTH-1:0] ramRdata,
    output logic                  oorErr
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_P0   = 2'd1,
        TAG_P1   = 2'd2
    } tag_t;

    // One extra bit so that DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

    tag_t                  r_tag, w_tag_next;
    logic                  r_oob, w_oob_next;
    logic                  r_oor_err;
    logic                  w_force1;
    logic                  w_any;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_in_range;
    logic                  w_rd_issue;
    logic [DATA_WIDTH-1:0] w_rdata;

`ifdef RAM_ARB_STARVE_GUARD_EN
    localparam int            CW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LP_LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_starve_cnt;

    assign w_force1 = (r_starve_cnt == LP_LIMIT);

    // Counts consecutive contested losses; any port-1 win or any cycle with
    // port 1 idle (including a withdrawn request) starts the count over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_starve_cnt <= '0;
        else if (gnt1 || !req1)
            r_starve_cnt <= '0;
        else if (req0 && gnt0 && r_starve_cnt != LP_LIMIT)
            r_starve_cnt <= r_starve_cnt + CW'(1);
    end
`else
    assign w_force1 = 1'b0;
`endif

    // Grants are gated by rst so nothing is accepted while in reset.
    assign gnt0 = !rst && req0 && !(req1 && w_force1);
    assign gnt1 = !rst && req1 && !gnt0;
    assign w_any = gnt0 || gnt1;

    assign w_sel_we    = gnt1 ? we1    : we0;
    assign w_sel_addr  = gnt1 ? addr1  : addr0;
    assign w_sel_wdata = gnt1 ? wdata1 : wdata0;
    assign w_in_range  = ({1'b0, w_sel_addr} < LP_DEPTH);

    // Out-of-range requests are still granted, but they never reach the RAM.
    assign ramWe      = w_any && w_sel_we && w_in_range;
    assign ramWaddr   = ramWe ? w_sel_addr  : '0;
    assign ramWdata   = ramWe ? w_sel_wdata : '0;
    assign w_rd_issue = w_any && !w_sel_we && w_in_range;
    assign ramRaddr   = w_rd_issue ? w_sel_addr : '0;

    // The read-return owner is rewritten at every edge. Back-to-back reads
    // from alternating ports therefore return in order with no bubbles.
    always_comb begin
        w_tag_next = TAG_NONE;
        w_oob_next = 1'b0;
        if (w_any && !w_sel_we) begin
            w_tag_next = gnt1 ? TAG_P1 : TAG_P0;
            w_oob_next = !w_in_range;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag     <= TAG_NONE;
            r_oob     <= 1'b0;
            r_oor_err <= 1'b0;
        end else begin
            r_tag     <= w_tag_next;
            r_oob     <= w_oob_next;
            r_oor_err <= w_any && !w_in_range;
        end
    end

    assign rvalid0 = (r_tag == TAG_P0);
    assign rvalid1 = (r_tag == TAG_P1);
    assign w_rdata = r_oob ? '0 : ramRdata;
    assign rdata0  = rvalid0 ? w_rdata : '0;
    assign rdata1  = rvalid1 ? w_rdata : '0;
    assign oorErr  = r_oor_err;

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single data RAM (separate read/write address ports, synchronous 1-cycle read) between two requesters: port 0 is the CPU load/store path, port 1 is a secondary master (DMA/debug loader). The arbiter issues at most one RAM operation per cycle. It routes read data back to the owning port, and a starvation guard keeps port 1 from being locked out by a busy CPU. It sits between the CPU core logic and the RAM instance, in the same clock domain as the RAM.

## Interface
- DATA_WIDTH, 16, RAM word width
- ADDR_WIDTH, 16, request/RAM address width
- DEPTH, 8192, number of implemented RAM words; addresses >= DEPTH are out of range
- STARVE_LIMIT, 4, contested cycles port 1 may lose before it is forced to win (>= 1)

Ports:
- clk  in  1  clock (RAM clock domain)
- rst  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  request valid, port 0 / 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_WIDTH  word address
- wdata0 / wdata1  in  DATA_WIDTH  write data
- gnt0 / gnt1  out  1  request accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid (registered pulse)
- rdata0 / rdata1  out  DATA_WIDTH  read data; 0 when corresponding rvalid is low
- ramWe  out  1  RAM write enable
- ramWaddr / ramRaddr  out  ADDR_WIDTH  RAM write / read address
- ramWdata  out  DATA_WIDTH  RAM write data
- ramRdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after ramRaddr is sampled
- oorErr  out  1  registered pulse: previous granted request was out of range

## Operation
- Requester rule: assert reqN with weN/addrN/wdataN stable; hold them until a posedge with gntN = 1. The op completes at that edge. Deasserting reqN before grant withdraws the request with no side effects.
- Grant selection (combinational, each cycle): only req0 -> gnt0; only req1 -> gnt1; both -> port 0, unless the starvation guard forces port 1; neither -> no grant. gnt0 and gnt1 are never both 1.
- Granted write, in range: ramWe = 1, ramWaddr = addr, ramWdata = wdata, committed at the edge.
- Granted read, in range: ramRaddr = addr. At the next cycle rvalidN = 1 for exactly one cycle, and rdataN = ramRdata.
- Out of range (addr >= DEPTH): the request is still granted; ramWe stays 0. A read returns rvalidN = 1 with rdataN = 0. oorErr pulses the next cycle.
- When idle: ramWe = 0; ramWaddr and ramRaddr hold 0.
- Read return tracking: a registered 2-bit state, rdTag ∈ {NONE, P0, P1}, plus an oob flag. It is set at every grant edge (NONE for writes and idle cycles), so back-to-back reads from alternating ports return in order, one per cycle.
- Starvation counter starveCnt, width clog2(STARVE_LIMIT+1):
  - increments (saturating at STARVE_LIMIT) on edges where req0 & req1 and port 0 is granted;
  - clears on any gnt1 edge, or any edge where req1 = 0.
  - When starveCnt == STARVE_LIMIT and both ports request, port 1 wins.

## Timing
- Grant latency 0 cycles: a request is granted in the same cycle it is presented if it wins.
- Write latency: data is in RAM after the granted edge.
- Read latency: exactly 1 cycle from the grant edge to rvalid. The arbiter sustains one op per cycle, with no bubbles.
- Reset values: gnt0 = gnt1 = 0 while rst is high (grant gated by rst); rvalid0 = rvalid1 = 0; rdata0 = rdata1 = 0; oorErr = 0; ramWe = 0; rdTag = NONE; starveCnt = 0.
- Reset during an outstanding read: the pending rvalid is dropped and never reappears after reset releases.
- A grant in the same cycle that an rvalid returns for the same port is legal and independent.

## Configuration
- RAM_ARB_STARVE_GUARD_EN defined: the starvation counter and forced port-1 win are implemented as described.
- Not defined: no counter exists, and port 0 has strict fixed priority. Port 1 is granted only in cycles where req0 = 0. All other behaviour is identical.

## Test plan
- Single read: port 0 writes 0xBEEF to addr 0x0010, then reads 0x0010 -> gnt0 in the request cycle, ramWe pulse on the write, and rvalid0 = 1 with rdata0 = 0xBEEF exactly one cycle after the read grant; rvalid1 stays 0.
- Alternating back-to-back reads: port 0 reads addr 1 (=0x1111) and port 1 reads addr 2 (=0x2222) on consecutive cycles -> rvalid0 with 0x1111, then rvalid1 with 0x2222 on the next cycle, with no idle cycle.
- Contention (guard enabled, STARVE_LIMIT = 4): req0 and req1 held continuously -> gnt0 for 4 cycles, gnt1 on the 5th, then the pattern repeats. Without the macro, gnt1 never asserts while req0 = 1.
- Out of range: port 1 writes 0x1234 to addr 8192, then reads addr 8192 -> both are granted, ramWe stays 0, oorErr pulses after each, rvalid1 = 1 with rdata1 = 0; RAM contents are unchanged.
- Reset mid-read: port 0 read granted, rst asserted before the next edge -> rvalid0 never asserts, all outputs are 0, and starveCnt = 0 after release.
- Withdrawal: req1 raised during port-0 contention, then dropped before its grant -> no port-1 access occurs and starveCnt returns to 0.
